axi_mgr_wr: RTL
===============

AXI_MGR_WR -- requirements
Module: axi_mgr_wr

Interface
REQ-001 SHALL have parameter AW, default 32, AXI/request address width.
REQ-002 SHALL have parameter DW, default 32, data width; BC=DW/8 and BW=$clog2(BC) are derived.
REQ-003 SHALL have parameter UW, default 32, user width.
REQ-004 SHALL have parameter IW, default 1, ID width.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port m_axi_if  axi_if.w_mgr  -  AXI AW/W/B manager channels.
REQ-008 SHALL have port req_valid  input  1  command valid.
REQ-009 SHALL have port req_ready  output  1  command accepted.
REQ-010 SHALL have ports req_addr AW, req_len 8, req_size 3, req_burst 2, req_user UW, req_id IW, req_lock 1, all inputs carrying AXI command fields.
REQ-011 SHALL have ports wvalid input 1, wready output 1, wdata input DW, wstrb input BC; this is the component data stream.
REQ-012 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_resp output 2 (axi_resp_e), rsp_id output IW; this is the completion.

Function
REQ-013 SHALL use FSM states IDLE, XFER, RESP, CMPL, and DRAIN (DRAIN exists only per REQ-027), with one transaction outstanding.
REQ-014 SHALL drive req_ready=1 only in IDLE; a req_valid&&req_ready handshake latches all command fields, loads beat_cnt=req_len, and moves to XFER.
REQ-015 SHALL register awvalid: it asserts in the first XFER cycle and holds until awready; an aw_done flag then sets and awvalid is never reasserted within the transaction.
REQ-016 SHALL drive AW fields from latched context; awlock SHALL equal latched lock; AW fields SHALL be stable while awvalid=1.
REQ-017 SHALL pass the W channel through combinationally in XFER while beats remain: m wvalid=wvalid, wready=m wready, wdata/wstrb passed, wlast=(beat_cnt==0); W may precede AW acceptance.
REQ-018 SHALL decrement beat_cnt on each W handshake; after the wlast handshake both wvalid toward AXI and wready SHALL be 0.
REQ-019 SHALL transition XFER->RESP when aw_done and the last beat are both complete, including when both complete in the same cycle.
REQ-020 SHALL drive bready=1 only in RESP; on a B handshake it latches bresp/bid and moves to CMPL.
REQ-021 SHALL set rsp_resp=bresp and rsp_id=latched id; if bid differs from the latched id, rsp_resp SHALL be SLVERR.
REQ-022 SHALL hold rsp_valid=1 in CMPL until rsp_ready, then return to IDLE; the next command is accepted no earlier than the cycle after the handshake.
REQ-023 SHALL ignore bvalid outside RESP; in every state other than XFER, wready=0 and AXI wvalid=0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, awvalid=0, bready=0, rsp_valid=0, aw_done=0, beat_cnt=0, rsp_resp=OKAY, and rsp_id=0.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction with no response generated; req_ready=1 in the first cycle after release.

Configuration
REQ-026 SHALL compile a 4KB-boundary check in when macro AXI_MGR_WR_4K_CHK_EN is defined.
REQ-027 SHALL, when AXI_MGR_WR_4K_CHK_EN is defined, treat an INCR command with req_addr[11:0] + ((req_len+1)<<req_size) > 4096 as illegal: enter DRAIN, issue no AW/W, assert wready=1 for req_len+1 beats, then enter CMPL with rsp_resp=SLVERR.
REQ-028 SHALL, when AXI_MGR_WR_4K_CHK_EN is undefined, omit DRAIN and forward every command to AXI unchanged.

Verification
REQ-029 SHALL cover single beat: addr=0x100, len=0, size=2, data=0xDEADBEEF, bresp=OKAY -> one AW and one W with wlast=1; rsp_resp=OKAY, rsp_id=req_id.
REQ-030 SHALL cover burst with backpressure: len=3 INCR, awready delayed 5 cycles while W accepted first -> wlast only on beat 4; one AW; RESP entered only after both channels are done.
REQ-031 SHALL cover B error and ID mismatch: bresp=SLVERR -> rsp_resp=SLVERR; bresp=OKAY with bid!=req_id -> rsp_resp=SLVERR.
REQ-032 SHALL cover the 4KB check: addr=0xFF8, len=3, size=2 with macro defined -> no awvalid, 4 beats drained, rsp_resp=SLVERR; same command without the macro -> normal AXI burst.
REQ-033 SHALL cover reset mid-burst: rst_n low after beat 2 of len=7 -> awvalid/bready/rsp_valid=0 immediately; req_ready=1 after release.
REQ-034 SHALL cover exclusive: req_lock=1, bresp=EXOKAY -> awlock=1, rsp_resp=EXOKAY.

Source files
------------

// File: rtl/axi_mgr_wr_if.sv
// axi_pkg: shared AXI response encoding.
// axi_if: AXI write-side bundle (AW/W/B) with manager/subordinate views.
package axi_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;
endpackage

interface axi_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int UW = 32,
  parameter int IW = 1
) ();
  localparam int BC = DW / 8;

  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awlock;
  logic [UW-1:0] awuser;
  logic [IW-1:0] awid;

  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [BC-1:0] wstrb;
  logic          wlast;

  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic [IW-1:0] bid;

  modport w_mgr (
    output awvalid, awaddr, awlen, awsize,
    output awburst, awlock, awuser, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport w_sub (
    input  awvalid, awaddr, awlen, awsize,
    input  awburst, awlock, awuser, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/axi_mgr_wr.sv
// axi_mgr_wr: single-outstanding AXI write manager (command, W pass-through, B).
// Optional 4KB-crossing guard compiled in by AXI_MGR_WR_4K_CHK_EN.
module axi_mgr_wr
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int UW = 32,
  parameter int IW = 1,
  localparam int BC = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  axi_if.w_mgr          m_axi_if,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_len,
  input  logic [2:0]    req_size,
  input  logic [1:0]    req_burst,
  input  logic [UW-1:0] req_user,
  input  logic [IW-1:0] req_id,
  input  logic          req_lock,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  input  logic [BC-1:0] wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output axi_resp_e     rsp_resp,
  output logic [IW-1:0] rsp_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_RESP,
    S_CMPL
`ifdef AXI_MGR_WR_4K_CHK_EN
    , S_DRAIN
`endif
  } state_e;

  state_e r_state;
  state_e w_next;

  logic [AW-1:0] r_addr;
  logic [7:0]    r_len;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic [UW-1:0] r_user;
  logic [IW-1:0] r_id;
  logic          r_lock;
  logic [7:0]    r_beat_cnt;
  logic          r_awvalid;
  logic          r_aw_done;
  logic          r_w_done;
  axi_resp_e     r_rsp_resp;
  logic [IW-1:0] r_rsp_id;

  logic w_req_hs;
  logic w_aw_hs;
  logic w_w_act;
  logic w_w_hs;
  logic w_b_hs;
  logic w_last;
  logic w_drain;
  logic w_d_hs;
  logic w_illegal;

`ifdef AXI_MGR_WR_4K_CHK_EN
  // End offset of the burst within its 4KB page; beyond 4096 crosses.
  logic [16:0] w_end;
  assign w_end = {5'd0, req_addr[11:0]}
               + ({8'd0, {1'b0, req_len} + 9'd1} << req_size);
  assign w_illegal = (req_burst == 2'b01) && (w_end > 17'd4096);
  assign w_drain   = (r_state == S_DRAIN);
`else
  assign w_illegal = 1'b0;
  assign w_drain   = 1'b0;
`endif

  assign req_ready = (r_state == S_IDLE);
  assign w_req_hs  = req_valid && req_ready;
  assign w_w_act   = (r_state == S_XFER) && !r_w_done;
  assign w_last    = (r_beat_cnt == 8'd0);

  assign m_axi_if.awvalid = r_awvalid;
  assign m_axi_if.awaddr  = r_addr;
  assign m_axi_if.awlen   = r_len;
  assign m_axi_if.awsize  = r_size;
  assign m_axi_if.awburst = r_burst;
  assign m_axi_if.awlock  = r_lock;
  assign m_axi_if.awuser  = r_user;
  assign m_axi_if.awid    = r_id;
  assign w_aw_hs = r_awvalid && m_axi_if.awready;

  assign m_axi_if.wvalid = wvalid && w_w_act;
  assign m_axi_if.wdata  = wdata;
  assign m_axi_if.wstrb  = wstrb;
  assign m_axi_if.wlast  = w_w_act && w_last;
  assign wready   = (m_axi_if.wready && w_w_act) || w_drain;
  assign w_w_hs   = m_axi_if.wvalid && m_axi_if.wready;
  assign w_d_hs   = w_drain && wvalid;

  assign m_axi_if.bready = (r_state == S_RESP);
  assign w_b_hs = m_axi_if.bready && m_axi_if.bvalid;

  assign rsp_valid = (r_state == S_CMPL);
  assign rsp_resp  = r_rsp_resp;
  assign rsp_id    = r_rsp_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_XFER;
`ifdef AXI_MGR_WR_4K_CHK_EN
        if (req_valid && w_illegal) w_next = S_DRAIN;
`endif
      end
      S_XFER: begin
        if ((r_aw_done || w_aw_hs) &&
            (r_w_done || (w_w_hs && w_last)))
          w_next = S_RESP;
      end
      S_RESP: if (m_axi_if.bvalid) w_next = S_CMPL;
      S_CMPL: if (rsp_ready) w_next = S_IDLE;
`ifdef AXI_MGR_WR_4K_CHK_EN
      S_DRAIN: if (wvalid && w_last) w_next = S_CMPL;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_user     <= '0;
      r_id       <= '0;
      r_lock     <= 1'b0;
      r_beat_cnt <= '0;
      r_awvalid  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rsp_resp <= OKAY;
      r_rsp_id   <= '0;
    end else begin
      if (w_req_hs) begin
        r_addr     <= req_addr;
        r_len      <= req_len;
        r_size     <= req_size;
        r_burst    <= req_burst;
        r_user     <= req_user;
        r_id       <= req_id;
        r_lock     <= req_lock;
        r_beat_cnt <= req_len;
        r_awvalid  <= !w_illegal;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
      end
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs || w_d_hs) begin
        if (w_last) r_w_done <= 1'b1;
        else        r_beat_cnt <= r_beat_cnt - 8'd1;
      end
      // An ID mismatch means the B belongs to someone else: report error.
      if (w_b_hs) begin
        r_rsp_resp <= (m_axi_if.bid != r_id) ? SLVERR
                    : axi_resp_e'(m_axi_if.bresp);
        r_rsp_id   <= r_id;
      end
      if (w_d_hs && w_last) begin
        r_rsp_resp <= SLVERR;
        r_rsp_id   <= r_id;
      end
    end
  end

endmodule
